aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 209 ++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 decryption core with on-the-fly reverse key schedule

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // entry a lives at bit offset (255-a)*8
    assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes_decrypt_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] pt
);
    typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

    state_t       state, state_nx;
    logic [127:0] st, st_nx, rk, rk_nx, pt_nx;
    logic [3:0]   rnd, rnd_nx;
    logic         busy_nx, done_nx;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8*(r + 4*c) -: 8] = x[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
        return y;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
        return {inv_mix_col(x[127:96]), inv_mix_col(x[95:64]),
                inv_mix_col(x[63:32]), inv_mix_col(x[31:0])};
    endfunction

    // One SubWord serves both directions: forward uses w3, reverse uses w3^w2 (= previous w3)
    logic [7:0]   rc;
    logic [31:0]  p3, sw_in, sw_out;
    logic [31:0]  n0, n1, n2, n3, p0, p1, p2;
    logic [127:0] kexp, prk, isr, isb, t, imc;

    assign rc    = rcon(rnd);
    assign p3    = rk[31:0] ^ rk[63:32];
    assign sw_in = (state == DEC) ? {p3[23:0], p3[31:24]} : {rk[23:0], rk[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sw
            aes_sbox u_sbox (.a(sw_in[31 - 8*g -: 8]), .y(sw_out[31 - 8*g -: 8]));
        end
        for (g = 0; g < 16; g++) begin : g_isb
            aes_inv_sbox u_isbox (.a(isr[127 - 8*g -: 8]), .y(isb[127 - 8*g -: 8]));
        end
    endgenerate

    assign n0   = rk[127:96] ^ sw_out ^ {rc, 24'h0};
    assign n1   = n0 ^ rk[95:64];
    assign n2   = n1 ^ rk[63:32];
    assign n3   = n2 ^ rk[31:0];
    assign kexp = {n0, n1, n2, n3};

    assign p2   = rk[63:32] ^ rk[95:64];
    assign p1   = rk[95:64] ^ rk[127:96];
    assign p0   = rk[127:96] ^ sw_out ^ {rc, 24'h0};
    assign prk  = {p0, p1, p2, p3};

    assign isr  = inv_shift_rows(st);
    assign t    = isb ^ prk;
    assign imc  = inv_mix_columns(t);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rnd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pt    <= '0;
        end else begin
            state <= state_nx;
            st    <= st_nx;
            rk    <= rk_nx;
            rnd   <= rnd_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            pt    <= pt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        st_nx    = st;
        rk_nx    = rk;
        rnd_nx   = rnd;
        busy_nx  = busy;
        done_nx  = 1'b0;
        pt_nx    = pt;
        case (state)
            IDLE: begin
                if (start) begin
                    st_nx    = ct;
                    rk_nx    = key;
                    rnd_nx   = 4'd1;
                    busy_nx  = 1'b1;
                    state_nx = KEXP;
                end
            end
            KEXP: begin
                rk_nx = kexp;
                if (rnd == 4'd10) begin
                    st_nx    = st ^ kexp;
                    state_nx = DEC;
                end else begin
                    rnd_nx = rnd + 4'd1;
                end
            end
            DEC: begin
                if (rnd > 4'd1) begin
                    st_nx  = imc;
                    rk_nx  = prk;
                    rnd_nx = rnd - 4'd1;
                end else begin
                    pt_nx    = t;
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - directed and round-trip bench for aes_decrypt_iter

module tb_aes_decrypt_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] ct, key;
    logic         busy, done;
    logic [127:0] pt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox [256];

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_decrypt_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ct    (ct),
        .key   (key),
        .busy  (busy),
        .done  (done),
        .pt    (pt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] x, input int i);
        return x[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last);
        logic [127:0] y, z;
        logic [7:0] a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127 - 8*(r + 4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
        if (last) return y;
        z = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(y, 4*c); a1 = gb(y, 4*c + 1); a2 = gb(y, 4*c + 2); a3 = gb(y, 4*c + 3);
            z[127 - 32*c -: 32] = {gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3,
                                   a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3,
                                   a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03),
                                   gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02)};
        end
        return z;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] s = p ^ k;
        logic [31:0]  w0, w1, w2, w3, sw;
        logic [7:0]   rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
            sw = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
            w0 = w0 ^ sw ^ {rc, 24'h0};
            w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            k  = {w0, w1, w2, w3};
            rc = gm(rc, 8'h02);
            s  = enc_round(s, r == 10) ^ k;
        end
        return s;
    endfunction

    task automatic run_block(input logic [127:0] c, input logic [127:0] k,
                             output logic [127:0] p, output int lat,
                             output logic b0, output logic bd, output logic dn);
        @(negedge clk);
        ct = c; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b0 = busy;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p  = pt;
        bd = busy;
        @(posedge clk); #1;
        dn = done;
    endtask

    logic [127:0] got, p_r, k_r;
    logic         b0, bd, dn;
    int           lat, n, cyc;
    int           dcyc [2];
    logic [127:0] dpt [2];

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        rst = 1'b1; start = 1'b0; ct = '0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_pt", pt, '0);
        @(negedge clk) rst = 1'b0;

        run_block(CT_C1, K_C1, got, lat, b0, bd, dn);
        check("c1_busy_after_accept", 128'(b0), 128'(1));
        check("c1_latency", 128'(lat), 128'(21));
        check("c1_pt", got, PT_C1);
        check("c1_busy_low_with_done", 128'(bd), 128'(0));
        check("c1_done_one_cycle", 128'(dn), 128'(0));

        run_block(CT_B, K_B, got, lat, b0, bd, dn);
        check("appb_latency", 128'(lat), 128'(21));
        check("appb_pt", got, PT_B);

        run_block(CT_Z, '0, got, lat, b0, bd, dn);
        check("zero_pt", got, '0);

        // start held high across two blocks; inputs switch to the second vector mid-flight
        @(negedge clk);
        ct = CT_C1; key = K_C1; start = 1'b1;
        @(posedge clk); #1;
        ct = CT_B; key = K_B;
        n = 0; cyc = 1;
        for (int i = 0; i < 60 && n < 2; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                dcyc[n] = cyc;
                dpt[n]  = pt;
                n++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("held_done_count", 128'(n), 128'(2));
        check("held_first_latency", 128'(dcyc[0]), 128'(21));
        check("held_spacing", 128'(dcyc[1] - dcyc[0]), 128'(21));
        check("held_first_pt", dpt[0], PT_C1);
        check("held_second_pt", dpt[1], PT_B);

        // asynchronous reset between edges, twelve cycles into a block
        @(negedge clk);
        ct = CT_B; key = K_B; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_pt", pt, '0);
        @(negedge clk) rst = 1'b0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        check("abort_no_done", 128'(n), 128'(0));
        check("abort_idle", 128'(busy), 128'(0));
        run_block(CT_C1, K_C1, got, lat, b0, bd, dn);
        check("after_abort_latency", 128'(lat), 128'(21));
        check("after_abort_pt", got, PT_C1);

        for (int i = 0; i < 50; i++) begin
            p_r = {$urandom, $urandom, $urandom, $urandom};
            k_r = {$urandom, $urandom, $urandom, $urandom};
            run_block(encrypt(p_r, k_r), k_r, got, lat, b0, bd, dn);
            check($sformatf("roundtrip_%0d", i), got, p_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
